// File: rtl/lcd_hd44780_pkg.sv
// Shared constants, FSM states and address-counter helpers for the HD44780 responder.
package lcd_hd44780_pkg;

   localparam int unsigned DDRAM_BYTES = 80;

   localparam logic [6:0] LINE0_BASE  = 7'h00;
   localparam logic [6:0] LINE0_LIMIT = 7'h27;
   localparam logic [6:0] LINE1_BASE  = 7'h40;
   localparam logic [6:0] LINE1_LIMIT = 7'h67;

   localparam logic [7:0] SPACE = 8'h20;

   // Instruction opcode masks; decode priority goes to the highest set bit.
   localparam logic [7:0] OP_SET_DDRAM   = 8'h80;
   localparam logic [7:0] OP_SET_CGRAM   = 8'h40;
   localparam logic [7:0] OP_FUNC_SET    = 8'h20;
   localparam logic [7:0] OP_SHIFT       = 8'h10;
   localparam logic [7:0] OP_DISP_CTRL   = 8'h08;
   localparam logic [7:0] OP_ENTRY_MODE  = 8'h04;
   localparam logic [7:0] OP_RETURN_HOME = 8'h02;
   localparam logic [7:0] OP_CLEAR       = 8'h01;

   typedef enum logic [1:0] {
      StIdle,
      StExec,
      StClearFill
   } lcd_state_e;

   // True when addr lies inside one of the two visible 40-byte lines.
   function automatic logic lcd_addr_legal(input logic [6:0] addr);
      return (addr <= LINE0_LIMIT) || ((addr >= LINE1_BASE) && (addr <= LINE1_LIMIT));
   endfunction

   // One AC step with wrap between the two lines in both directions.
   function automatic logic [6:0] lcd_ac_step(input logic [6:0] ac, input logic inc);
      logic [6:0] nxt;
      if (inc) begin
         if (ac == LINE0_LIMIT)      nxt = LINE1_BASE;
         else if (ac == LINE1_LIMIT) nxt = LINE0_BASE;
         else                        nxt = ac + 7'd1;
      end else begin
         if (ac == LINE1_BASE)       nxt = LINE0_LIMIT;
         else if (ac == LINE0_BASE)  nxt = LINE1_LIMIT;
         else                        nxt = ac - 7'd1;
      end
      return nxt;
   endfunction

endpackage

// File: rtl/lcd_ddram.sv
// 80x8 display data RAM: AC-indexed read/write port, clear-fill write path, debug read port.
module lcd_ddram
   import lcd_hd44780_pkg::*;
(
   input  logic       clk,
   input  logic [6:0] a_addr,
   input  logic       a_we,
   input  logic [7:0] a_wdata,
   output logic [7:0] a_rdata,
   input  logic       fill_we,
   input  logic [6:0] fill_idx,
   input  logic [6:0] b_addr,
   output logic [7:0] b_rdata
);

   logic [7:0] mem [DDRAM_BYTES];

   // Line 1 (0x40..0x67) packs directly after line 0 at index 40.
   function automatic logic [6:0] addr_idx(input logic [6:0] a);
      return a[6] ? (a - 7'd24) : a;
   endfunction

   logic [6:0] a_idx, b_idx;
   logic       a_ok, b_ok;

   assign a_idx = addr_idx(a_addr);
   assign b_idx = addr_idx(b_addr);
   assign a_ok  = lcd_addr_legal(a_addr);
   assign b_ok  = lcd_addr_legal(b_addr);

   // Contents survive reset; clear-fill and host writes never coincide.
   always_ff @(posedge clk) begin
      if (fill_we) begin
         mem[fill_idx] <= SPACE;
      end else if (a_we && a_ok) begin
         mem[a_idx] <= a_wdata;
      end
      a_rdata <= a_ok ? mem[a_idx] : 8'h00;
      b_rdata <= b_ok ? mem[b_idx] : 8'h00;
   end

endmodule

// File: rtl/lcd_hd44780_responder.sv
// Panel end of an 8-bit HD44780 bus: synchronises E/RS/RW/DB, executes a command subset,
// keeps DDRAM, AC and the busy flag, and drives DB during reads.
module lcd_hd44780_responder
   import lcd_hd44780_pkg::*;
#(
   parameter int unsigned BUSY_CYCLES       = 2000,
   parameter int unsigned CLEAR_BUSY_CYCLES = 76000,
   parameter int unsigned CNT_W             = 17
) (
   input  logic       clk,
   input  logic       reset_n,
   input  logic       lcd_e,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic [7:0] lcd_data_in,
   output logic [7:0] lcd_data_out,
   output logic       lcd_data_oe,
   output logic       busy,
   output logic       overrun,
   input  logic [6:0] dbg_addr,
   output logic [7:0] dbg_data
);

   // Synchroniser chain; e_q is the extra stage used for edge detection.
   logic       e_s1, e_s2, e_q;
   logic       rs_s1, rs_s2, rw_s1, rw_s2;
   logic [7:0] data_s1, data_s2;

   // Two-flop synchronisers for every bus input, sampled in lock-step with E.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         {e_s1, e_s2, e_q}   <= 3'b000;
         {rs_s1, rs_s2}      <= 2'b00;
         {rw_s1, rw_s2}      <= 2'b00;
         {data_s1, data_s2}  <= 16'h0000;
      end else begin
         {e_s1, e_s2, e_q}   <= {lcd_e, e_s1, e_s2};
         {rs_s1, rs_s2}      <= {lcd_rs, rs_s1};
         {rw_s1, rw_s2}      <= {lcd_rw, rw_s1};
         {data_s1, data_s2}  <= {lcd_data_in, data_s1};
      end
   end

   logic e_rise, e_fall;
   assign e_rise = e_s2 & ~e_q;
   assign e_fall = ~e_s2 & e_q;

   // Core state.
   lcd_state_e       state_q, state_d;
   logic [6:0]       ac_q, ac_d;
   logic             id_q, id_d;
   logic             s_q, s_d;
   logic [2:0]       disp_q, disp_d;
   logic [4:0]       func_q, func_d;
   logic [6:0]       fill_q, fill_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             overrun_q, overrun_d;
   logic             cmd_rs_q, cmd_rs_d;
   logic [7:0]       cmd_data_q, cmd_data_d;

   // Bus-cycle type captured at the E rising edge; it also decides the falling-edge action.
   logic             cap_rs_q, cap_rw_q;
   logic             oe_q;
   logic [7:0]       dout_q;

   logic             ram_we, fill_we;
   logic [7:0]       ram_rdata;

   assign busy    = (cnt_q != '0);
   assign overrun = overrun_q;

   // Bus driver: latch read data on E rise, release DB on E fall or reset.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         oe_q     <= 1'b0;
         dout_q   <= 8'h00;
         cap_rs_q <= 1'b0;
         cap_rw_q <= 1'b0;
      end else if (e_rise) begin
         cap_rs_q <= rs_s2;
         cap_rw_q <= rw_s2;
         if (rw_s2) begin
            oe_q   <= 1'b1;
            dout_q <= rs_s2 ? ram_rdata : {busy, ac_q};
         end
      end else if (e_fall) begin
         oe_q <= 1'b0;
      end
   end

   assign lcd_data_oe  = oe_q;
   assign lcd_data_out = dout_q;

   // Command FSM, AC, busy counter and mode registers.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q    <= StIdle;
         ac_q       <= 7'h00;
         id_q       <= 1'b1;
         s_q        <= 1'b0;
         disp_q     <= 3'b000;
         func_q     <= 5'b00000;
         fill_q     <= 7'h00;
         cnt_q      <= '0;
         overrun_q  <= 1'b0;
         cmd_rs_q   <= 1'b0;
         cmd_data_q <= 8'h00;
      end else begin
         state_q    <= state_d;
         ac_q       <= ac_d;
         id_q       <= id_d;
         s_q        <= s_d;
         disp_q     <= disp_d;
         func_q     <= func_d;
         fill_q     <= fill_d;
         cnt_q      <= cnt_d;
         overrun_q  <= overrun_d;
         cmd_rs_q   <= cmd_rs_d;
         cmd_data_q <= cmd_data_d;
      end
   end

   // Next-state: accept bus cycles on E fall, execute one cycle later, then optional clear fill.
   always_comb begin
      state_d    = state_q;
      ac_d       = ac_q;
      id_d       = id_q;
      s_d        = s_q;
      disp_d     = disp_q;
      func_d     = func_q;
      fill_d     = fill_q;
      overrun_d  = overrun_q;
      cmd_rs_d   = cmd_rs_q;
      cmd_data_d = cmd_data_q;
      cnt_d      = busy ? (cnt_q - 1'b1) : cnt_q;
      ram_we     = 1'b0;
      fill_we    = 1'b0;

      if (e_fall) begin
         if (!cap_rw_q && busy) begin
            overrun_d = 1'b1;
         end else if (cap_rw_q && cap_rs_q) begin
            ac_d = lcd_ac_step(ac_q, id_q);
         end else if (!cap_rw_q) begin
            cmd_rs_d   = cap_rs_q;
            cmd_data_d = data_s2;
            state_d    = StExec;
         end
      end

      unique case (state_q)
         StIdle: begin
         end
         StExec: begin
            state_d = StIdle;
            cnt_d   = CNT_W'(BUSY_CYCLES);
            if (cmd_rs_q) begin
               ram_we = 1'b1;
               ac_d   = lcd_ac_step(ac_q, id_q);
            end else if ((cmd_data_q & OP_SET_DDRAM) != 8'h00) begin
               ac_d = lcd_addr_legal(cmd_data_q[6:0]) ? cmd_data_q[6:0] : LINE0_BASE;
            end else if ((cmd_data_q & OP_SET_CGRAM) != 8'h00) begin
               // CGRAM is not modelled.
            end else if ((cmd_data_q & OP_FUNC_SET) != 8'h00) begin
               func_d = cmd_data_q[4:0];
            end else if ((cmd_data_q & OP_SHIFT) != 8'h00) begin
               if (!cmd_data_q[3]) ac_d = lcd_ac_step(ac_q, cmd_data_q[2]);
            end else if ((cmd_data_q & OP_DISP_CTRL) != 8'h00) begin
               disp_d = cmd_data_q[2:0];
            end else if ((cmd_data_q & OP_ENTRY_MODE) != 8'h00) begin
               id_d = cmd_data_q[1];
               s_d  = cmd_data_q[0];
            end else if ((cmd_data_q & OP_RETURN_HOME) != 8'h00) begin
               ac_d  = LINE0_BASE;
               cnt_d = CNT_W'(CLEAR_BUSY_CYCLES);
            end else if ((cmd_data_q & OP_CLEAR) != 8'h00) begin
               ac_d    = LINE0_BASE;
               id_d    = 1'b1;
               fill_d  = 7'h00;
               cnt_d   = CNT_W'(CLEAR_BUSY_CYCLES);
               state_d = StClearFill;
            end
         end
         StClearFill: begin
            fill_we = 1'b1;
            fill_d  = fill_q + 7'd1;
            if (fill_q == 7'(DDRAM_BYTES - 1)) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   lcd_ddram u_ddram (
      .clk      (clk),
      .a_addr   (ac_q),
      .a_we     (ram_we),
      .a_wdata  (cmd_data_q),
      .a_rdata  (ram_rdata),
      .fill_we  (fill_we),
      .fill_idx (fill_q),
      .b_addr   (dbg_addr),
      .b_rdata  (dbg_data)
   );

endmodule

// File: tb/tb_lcd_hd44780_responder.sv
// Directed bench for the HD44780 responder with short busy times.
module tb_lcd_hd44780_responder;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic       lcd_e = 1'b0;
   logic       lcd_rs = 1'b0;
   logic       lcd_rw = 1'b0;
   logic [7:0] lcd_data_in = 8'h00;
   logic [7:0] lcd_data_out;
   logic       lcd_data_oe;
   logic       busy;
   logic       overrun;
   logic [6:0] dbg_addr = 7'h00;
   logic [7:0] dbg_data;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   lcd_hd44780_responder #(
      .BUSY_CYCLES       (20),
      .CLEAR_BUSY_CYCLES (100),
      .CNT_W             (17)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .lcd_e        (lcd_e),
      .lcd_rs       (lcd_rs),
      .lcd_rw       (lcd_rw),
      .lcd_data_in  (lcd_data_in),
      .lcd_data_out (lcd_data_out),
      .lcd_data_oe  (lcd_data_oe),
      .busy         (busy),
      .overrun      (overrun),
      .dbg_addr     (dbg_addr),
      .dbg_data     (dbg_data)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic bus_write(input logic rs, input logic [7:0] d);
      @(negedge clk);
      lcd_rs = rs; lcd_rw = 1'b0; lcd_data_in = d; lcd_e = 1'b1;
      repeat (4) @(negedge clk);
      lcd_e = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   task automatic bus_read(input logic rs, output logic [7:0] v, output logic oe_hi,
                           output logic oe_lo);
      @(negedge clk);
      lcd_rs = rs; lcd_rw = 1'b1; lcd_e = 1'b1;
      repeat (5) @(negedge clk);
      v = lcd_data_out; oe_hi = lcd_data_oe;
      lcd_e = 1'b0;
      repeat (4) @(negedge clk);
      oe_lo = lcd_data_oe;
      lcd_rw = 1'b0;
   endtask

   task automatic wait_idle(input string tag);
      int n = 0;
      while (busy && n < 500) begin
         @(negedge clk);
         n++;
      end
      check(tag, busy, 1'b0);
   endtask

   task automatic dbg_read(input logic [6:0] a, output logic [7:0] v);
      @(negedge clk);
      dbg_addr = a;
      @(negedge clk);
      v = dbg_data;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] v;
      logic       hi, lo;
      int         n, bad;

      // 1: reset and first status read
      repeat (3) @(negedge clk);
      check("rst_oe", lcd_data_oe, 1'b0);
      check("rst_dout", lcd_data_out, 8'h00);
      reset_n = 1'b1;
      @(negedge clk);
      check("rst_busy", busy, 1'b0);
      check("rst_overrun", overrun, 1'b0);
      bus_read(1'b0, v, hi, lo);
      check("status0", v, 8'h00);
      check("status0_oe_hi", hi, 1'b1);
      check("status0_oe_lo", lo, 1'b0);

      // 2: clear holds busy for exactly 100 clocks, then every visible byte is a space
      bus_write(1'b0, 8'h01);
      n = 0;
      while (busy && n < 200) begin
         n++;
         @(negedge clk);
      end
      check("clear_busy_len", n, 100);
      bad = 0;
      for (int a = 0; a < 8'h68; a++) begin
         if (a < 8'h28 || a >= 8'h40) begin
            dbg_read(7'(a), v);
            if (v !== 8'h20) bad++;
         end
      end
      check("clear_fill_bad", bad, 0);
      bus_read(1'b0, v, hi, lo);
      check("status_after_clear", v, 8'h00);

      // 3: entry increment, two data writes
      bus_write(1'b0, 8'h06); wait_idle("idle_entry");
      bus_write(1'b1, 8'h41); wait_idle("idle_wrA");
      bus_write(1'b1, 8'h42); wait_idle("idle_wrB");
      dbg_read(7'h00, v); check("ddram00_A", v, 8'h41);
      dbg_read(7'h01, v); check("ddram01_B", v, 8'h42);
      bus_read(1'b0, v, hi, lo);
      check("status_ac02", v, 8'h02);

      // 4: wrap forward from 0x27 and backward from 0x00
      bus_write(1'b0, 8'hA7); wait_idle("idle_setA7");
      bus_write(1'b1, 8'h55); wait_idle("idle_wr55");
      bus_read(1'b0, v, hi, lo);
      check("status_ac40", v, 8'h40);
      dbg_read(7'h27, v); check("ddram27", v, 8'h55);
      bus_write(1'b0, 8'h80); wait_idle("idle_set80");
      bus_write(1'b0, 8'h04); wait_idle("idle_entry_dec");
      bus_write(1'b1, 8'h33); wait_idle("idle_wr33");
      bus_read(1'b0, v, hi, lo);
      check("status_ac67", v, 8'h67);
      dbg_read(7'h00, v); check("ddram00_33", v, 8'h33);

      // 5: back-to-back write lands while busy
      bus_write(1'b1, 8'h77);
      check("busy_after_wr", busy, 1'b1);
      check("overrun_before", overrun, 1'b0);
      bus_write(1'b1, 8'h99);
      check("overrun_set", overrun, 1'b1);
      wait_idle("idle_overrun");
      dbg_read(7'h67, v); check("ddram67", v, 8'h77);
      dbg_read(7'h66, v); check("ddram66_untouched", v, 8'h20);
      bus_read(1'b0, v, hi, lo);
      check("status_ac66", v, 8'h66);
      check("overrun_sticky", overrun, 1'b1);

      // 6: data read with post-advance, then reset during a read
      bus_write(1'b0, 8'h06); wait_idle("idle_entry_inc");
      bus_write(1'b0, 8'h80); wait_idle("idle_set80b");
      bus_read(1'b1, v, hi, lo);
      check("data_read", v, 8'h33);
      check("data_read_oe", hi, 1'b1);
      bus_read(1'b0, v, hi, lo);
      check("status_ac01", v, 8'h01);

      @(negedge clk);
      lcd_rs = 1'b0; lcd_rw = 1'b1; lcd_e = 1'b1;
      repeat (5) @(negedge clk);
      check("oe_before_reset", lcd_data_oe, 1'b1);
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      check("oe_reset_drop", lcd_data_oe, 1'b0);
      check("overrun_reset", overrun, 1'b0);
      @(negedge clk);
      lcd_e = 1'b0; lcd_rw = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      bus_read(1'b0, v, hi, lo);
      check("status_after_reset", v, 8'h00);
      dbg_read(7'h00, v); check("ddram_kept", v, 8'h33);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
